// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and frame constants.
// Used by both the receiver and the transmitter rework.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 10417;
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Serial line and received-byte bundle between the UART receiver
// and its consumer.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] d_in;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        input  rx,
        output d_in,
        output valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  d_in,
        input  valid,
        input  frame_err,
        input  busy
    );

endinterface

// File: rtl/uart_rx_sync_ff.sv
// N-flop synchroniser for asynchronous inputs; resets to 1 so an
// idle-high line never looks active while reset is applied.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, finds the start bit, samples
// mid-bit and strobes each good byte or a framing error.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic rst,
    uart_rx_if.master bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] data_q, data_n;
    logic                 valid_q, valid_n;
    logic                 ferr_q, ferr_n;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shift   <= shift_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            ferr_q  <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = (cnt == BIT_LAST) ? '0 : cnt + 1'b1;
        idx_n   = idx;
        shift_n = shift;
        data_n  = data_q;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n   = '0;
                        idx_n   = '0;
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    shift_n[idx] = rx_s;
                    idx_n        = idx + 1'b1;
                    if (idx == IDX_LAST) state_n = STOP;
                end
            end
            STOP: begin
                // Return to IDLE mid stop bit so a following start edge is not missed
                if (cnt == BIT_LAST) begin
                    if (rx_s) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.d_in      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: vector table of single frames plus
// hand-written back-to-back, glitch, break and reset sequences.
module tb_uart_rx;

    localparam int CPB = 16;

    typedef struct {
        logic [7:0] data;
        int         period;
        logic [7:0] exp_d;
        logic [7:0] mask;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    uart_rx_if bus ();

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int nvalid = 0;
    int nferr  = 0;
    int both   = 0;
    int wide   = 0;
    int busy_v = 0;
    logic prev_v = 1'b0;
    logic prev_f = 1'b0;
    logic [7:0] capq[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.valid) begin
                nvalid <= nvalid + 1;
                capq.push_back(bus.d_in);
                if (bus.busy) busy_v <= busy_v + 1;
            end
            if (bus.frame_err) nferr <= nferr + 1;
            if (bus.valid && bus.frame_err) both <= both + 1;
            if ((bus.valid && prev_v) || (bus.frame_err && prev_f))
                wide <= wide + 1;
        end
        prev_v <= bus.valid;
        prev_f <= bus.frame_err;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int cap_at(input int k);
        if (k < capq.size()) return int'(capq[k]);
        return -1;
    endfunction

    task automatic bit_out(input logic v, input int p);
        bus.rx = v;
        repeat (p) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int p, input logic stop);
        bit_out(1'b0, p);
        for (int i = 0; i < 8; i++) bit_out(b[i], p);
        bit_out(stop, p);
    endtask

    vec_t vt[6];
    int v0, f0, q0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Fast-clock frame: only bits inside the drift margin are checked
        vt[0] = '{8'hA5, 16, 8'hA5, 8'hFF};
        vt[1] = '{8'h00, 16, 8'h00, 8'hFF};
        vt[2] = '{8'hFF, 16, 8'hFF, 8'hFF};
        vt[3] = '{8'h3C, 16, 8'h3C, 8'hFF};
        vt[4] = '{8'h96, 17, 8'h96, 8'hFF};
        vt[5] = '{8'h96, 15, 8'h96, 8'h3F};

        bus.rx = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset d_in", bus.d_in, 8'h00);
        check("reset valid", bus.valid, 0);
        check("reset frame_err", bus.frame_err, 0);
        check("reset busy", bus.busy, 0);
        rst = 1'b0;
        bit_out(1'b1, 5);

        for (int i = 0; i < 6; i++) begin
            v0 = nvalid;
            f0 = nferr;
            send(vt[i].data, vt[i].period, 1'b1);
            bit_out(1'b1, 2 * CPB);
            check($sformatf("vec%0d valid count", i), nvalid - v0, 1);
            check($sformatf("vec%0d frame_err count", i), nferr - f0, 0);
            check($sformatf("vec%0d d_in", i),
                  bus.d_in & vt[i].mask, vt[i].exp_d & vt[i].mask);
            check($sformatf("vec%0d busy idle", i), bus.busy, 0);
        end

        v0 = nvalid;
        f0 = nferr;
        q0 = capq.size();
        send(8'h00, CPB, 1'b1);
        send(8'hFF, CPB, 1'b1);
        send(8'h3C, CPB, 1'b1);
        bit_out(1'b1, 2 * CPB);
        check("b2b valid count", nvalid - v0, 3);
        check("b2b frame_err count", nferr - f0, 0);
        check("b2b byte0", cap_at(q0), 8'h00);
        check("b2b byte1", cap_at(q0 + 1), 8'hFF);
        check("b2b byte2", cap_at(q0 + 2), 8'h3C);

        v0 = nvalid;
        f0 = nferr;
        bit_out(1'b0, 5);
        bit_out(1'b1, 40);
        check("glitch valid count", nvalid - v0, 0);
        check("glitch frame_err count", nferr - f0, 0);
        check("glitch busy", bus.busy, 0);
        send(8'h81, CPB, 1'b1);
        bit_out(1'b1, 2 * CPB);
        check("after glitch valid count", nvalid - v0, 1);
        check("after glitch d_in", bus.d_in, 8'h81);

        v0 = nvalid;
        f0 = nferr;
        send(8'h55, CPB, 1'b0);
        bit_out(1'b0, 40 * CPB);
        check("break busy held", bus.busy, 1);
        bit_out(1'b1, 2 * CPB);
        check("break frame_err count", nferr - f0, 1);
        check("break valid count", nvalid - v0, 0);
        check("break d_in kept", bus.d_in, 8'h81);
        check("break busy released", bus.busy, 0);
        send(8'h12, CPB, 1'b1);
        bit_out(1'b1, 2 * CPB);
        check("after break valid count", nvalid - v0, 1);
        check("after break d_in", bus.d_in, 8'h12);

        v0 = nvalid;
        f0 = nferr;
        bit_out(1'b0, CPB);
        for (int i = 0; i < 3; i++) bit_out(((8'hC3 >> i) & 8'h01) != 0, CPB);
        bit_out(1'b0, CPB / 2);
        rst = 1'b1;
        #1;
        check("async reset d_in", bus.d_in, 8'h00);
        check("async reset busy", bus.busy, 0);
        check("async reset valid", bus.valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bit_out(1'b0, 7);
        check("low at reset release starts frame", bus.busy, 1);
        bit_out(1'b1, 4 * CPB);
        check("reset frame valid count", nvalid - v0, 0);
        check("reset frame frame_err count", nferr - f0, 0);
        check("reset frame busy", bus.busy, 0);
        send(8'h7E, CPB, 1'b1);
        bit_out(1'b1, 2 * CPB);
        check("after reset valid count", nvalid - v0, 1);
        check("after reset d_in", bus.d_in, 8'h7E);

        check("valid and frame_err together", both, 0);
        check("pulse wider than one cycle", wide, 0);
        check("busy high with valid", busy_v, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
